// File: rtl/waypoint_sequencer_if.sv
// Drive-controller link for waypoint_sequencer.
// Sequencer is master; the drive controller is slave.
interface waypoint_sequencer_if;
  logic signed [31:0] target_position_x;
  logic signed [31:0] target_position_y;
  logic signed [31:0] initial_position_x;
  logic signed [31:0] initial_position_y;
  logic               robot_controller_en;
  logic               ctrl_restart;
  logic               target_reached;

  modport master (
    output target_position_x,
    output target_position_y,
    output initial_position_x,
    output initial_position_y,
    output robot_controller_en,
    output ctrl_restart,
    input  target_reached
  );

  modport slave (
    input  target_position_x,
    input  target_position_y,
    input  initial_position_x,
    input  initial_position_y,
    input  robot_controller_en,
    input  ctrl_restart,
    output target_reached
  );
endinterface

// File: rtl/waypoint_sequencer.sv
// Waypoint sequencer: walks a (x,y) table, one controller leg per entry.
// Optional WAYPOINT_LOOP_EN: endless looping with a lap_count output.
module waypoint_sequencer #(
  parameter int DEPTH          = 8,
  parameter int AW             = 3,
  parameter int RESTART_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wp_wr_en,
  input  logic [AW-1:0]     wp_wr_addr,
  input  logic [31:0]       wp_wr_x,
  input  logic [31:0]       wp_wr_y,
  input  logic [AW:0]       wp_count,
  input  logic [31:0]       home_x,
  input  logic [31:0]       home_y,
  input  logic              start,
  input  logic              abort,
  input  logic              tick_1ms,
  input  logic [15:0]       timeout_ms,
  waypoint_sequencer_if.master ctrl,
  output logic [AW-1:0]     wp_index,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fault,
  output logic              wr_reject
`ifdef WAYPOINT_LOOP_EN
  ,
  output logic [7:0]        lap_count
`endif
);

  localparam int CW = $clog2(RESTART_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RESTART,
    S_RUN,
    S_NEXT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   tbl_x [DEPTH];
  logic [31:0]   tbl_y [DEPTH];

  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [1:0]    fault_q, fault_d;
  logic [1:0]    fault_now;
  logic [CW-1:0] rc_q;
  logic [15:0]   tmr_q, tmr_inc;
  logic          expire;
  logic          last;
  logic          rej_q;
  logic [31:0]   tgt_x_q, tgt_y_q;
  logic [31:0]   ini_x_q, ini_y_q;
  logic [31:0]   ini_x_d, ini_y_d;

`ifdef WAYPOINT_LOOP_EN
  logic          wrap_q;
  logic          lap_inc;
  logic          lap_clr;
  logic [7:0]    lap_q;
  logic [AW-1:0] wrap_idx;
`endif

  assign busy = (state_q == S_LOAD) || (state_q == S_RESTART) ||
                (state_q == S_RUN)  || (state_q == S_NEXT);

  assign last = ({1'b0, idx_q} == (wp_count - (AW+1)'(1)));

  assign tmr_inc = (tick_1ms && (tmr_q != 16'hFFFF)) ?
                   tmr_q + 16'd1 : tmr_q;
  assign expire  = (timeout_ms != 16'd0) && (tmr_inc == timeout_ms);

  assign ctrl.target_position_x  = tgt_x_q;
  assign ctrl.target_position_y  = tgt_y_q;
  assign ctrl.initial_position_x = ini_x_q;
  assign ctrl.initial_position_y = ini_y_q;
  assign ctrl.robot_controller_en = (state_q == S_RUN);
  assign ctrl.ctrl_restart        = (state_q == S_RESTART);

  assign wp_index  = idx_q;
  assign done      = done_q;
  assign fault     = fault_q | fault_now;
  assign wr_reject = rej_q;

`ifdef WAYPOINT_LOOP_EN
  assign wrap_idx  = AW'(wp_count - (AW+1)'(1));
  assign lap_clr   = start && !abort &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) ||
                      (state_q == S_FAULT));
  assign lap_inc   = !abort && (state_q == S_NEXT) && last;
  assign lap_count = lap_q;
`endif

  // Host table write; dropped while a sequence is running.
  always_ff @(posedge clk) begin
    if (wp_wr_en && !busy) begin
      tbl_x[wp_wr_addr] <= wp_wr_x;
      tbl_y[wp_wr_addr] <= wp_wr_y;
    end
  end

  // Start point of the leg: home, the previous entry, or last entry on wrap.
  always_comb begin
    ini_x_d = home_x;
    ini_y_d = home_y;
    if (idx_q != '0) begin
      ini_x_d = tbl_x[idx_q - AW'(1)];
      ini_y_d = tbl_y[idx_q - AW'(1)];
    end
`ifdef WAYPOINT_LOOP_EN
    else if (wrap_q) begin
      ini_x_d = tbl_x[wrap_idx];
      ini_y_d = tbl_y[wrap_idx];
    end
`endif
  end

  // State, leg index and sticky status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Next-state decode; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = done_q;
    fault_d   = fault_q;
    fault_now = 2'd0;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          if (wp_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fault_d = 2'd0;
          end else if (wp_count > (AW+1)'(DEPTH)) begin
            state_d = S_FAULT;
            done_d  = 1'b0;
            fault_d = 2'd2;
          end else begin
            state_d = S_LOAD;
            idx_d   = '0;
            done_d  = 1'b0;
            fault_d = 2'd0;
          end
        end
      end
      S_LOAD: state_d = S_RESTART;
      S_RESTART: begin
        if (rc_q == CW'(RESTART_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (ctrl.target_reached) begin
          state_d = S_NEXT;
        end else if (expire) begin
          state_d   = S_FAULT;
          fault_d   = 2'd1;
          fault_now = 2'd1;
        end
      end
      S_NEXT: begin
        if (last) begin
`ifdef WAYPOINT_LOOP_EN
          state_d = S_LOAD;
          idx_d   = '0;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_LOAD;
          idx_d   = idx_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      done_d    = 1'b0;
      fault_d   = 2'd0;
      fault_now = 2'd0;
    end
  end

  // Leg datapath: positions, restart counter, leg timer, reject pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rej_q   <= 1'b0;
      rc_q    <= '0;
      tmr_q   <= '0;
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      ini_x_q <= '0;
      ini_y_q <= '0;
    end else begin
      rej_q <= wp_wr_en && busy;
      rc_q  <= (state_q == S_RESTART) ? rc_q + CW'(1) : '0;
      if (state_q == S_RESTART) begin
        tmr_q <= '0;
      end else if (state_q == S_RUN) begin
        tmr_q <= tmr_inc;
      end
      if (state_q == S_LOAD) begin
        tgt_x_q <= tbl_x[idx_q];
        tgt_y_q <= tbl_y[idx_q];
        ini_x_q <= ini_x_d;
        ini_y_q <= ini_y_d;
      end
    end
  end

`ifdef WAYPOINT_LOOP_EN
  // Lap counter and wrap flag for the looping build.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
      lap_q  <= '0;
    end else begin
      if (lap_clr || abort) begin
        wrap_q <= 1'b0;
      end else if (lap_inc) begin
        wrap_q <= 1'b1;
      end
      if (lap_clr) begin
        lap_q <= '0;
      end else if (lap_inc && (lap_q != 8'hFF)) begin
        lap_q <= lap_q + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Self-checking bench for waypoint_sequencer (default build).
// Reference: table model arrays plus leg-by-leg expectations.
module tb_waypoint_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RC    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          wp_wr_en = 1'b0;
  logic [AW-1:0] wp_wr_addr = '0;
  logic [31:0]   wp_wr_x = '0;
  logic [31:0]   wp_wr_y = '0;
  logic [AW:0]   wp_count = '0;
  logic [31:0]   home_x = '0;
  logic [31:0]   home_y = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tick_1ms = 1'b0;
  logic [15:0]   timeout_ms = '0;
  logic [AW-1:0] wp_index;
  logic          busy;
  logic          done;
  logic [1:0]    fault;
  logic          wr_reject;

  waypoint_sequencer_if cif();

  waypoint_sequencer #(
    .DEPTH(DEPTH),
    .AW(AW),
    .RESTART_CYCLES(RC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wp_wr_en(wp_wr_en),
    .wp_wr_addr(wp_wr_addr),
    .wp_wr_x(wp_wr_x),
    .wp_wr_y(wp_wr_y),
    .wp_count(wp_count),
    .home_x(home_x),
    .home_y(home_y),
    .start(start),
    .abort(abort),
    .tick_1ms(tick_1ms),
    .timeout_ms(timeout_ms),
    .ctrl(cif),
    .wp_index(wp_index),
    .busy(busy),
    .done(done),
    .fault(fault),
    .wr_reject(wr_reject)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mx [DEPTH];
  logic [31:0] my [DEPTH];
  logic [31:0] hx = '0;
  logic [31:0] hy = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] x,
                    input logic [31:0] y);
    wp_wr_en   = 1'b1;
    wp_wr_addr = AW'(a);
    wp_wr_x    = x;
    wp_wr_y    = y;
    @(negedge clk);
    wp_wr_en = 1'b0;
    chk("wr_rej_idle", wr_reject, 0);
    mx[a] = x;
    my[a] = y;
  endtask

  task automatic set_home(input logic [31:0] x, input logic [31:0] y);
    hx = x;
    hy = y;
    home_x = x;
    home_y = y;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the LOAD cycle of leg 0; runs legs 0..upto-1.
  task automatic legs(input int n, input int upto, input int rdly,
                      input bit rej);
    int cnt;
    for (int l = 0; l < upto; l++) begin
      chk("load_busy", busy, 1);
      chk("load_idx", wp_index, l);
      chk("load_en", cif.robot_controller_en, 0);
      chk("load_rst", cif.ctrl_restart, 0);
      if (rej && l == 0) begin
        wp_wr_en   = 1'b1;
        wp_wr_addr = '0;
        wp_wr_x    = 32'hDEAD0001;
        wp_wr_y    = 32'hDEAD0002;
      end
      @(negedge clk);
      if (rej && l == 0) begin
        wp_wr_en = 1'b0;
        chk("wr_rej_pulse", wr_reject, 1);
      end
      chk("tgt_x", cif.target_position_x, mx[l]);
      chk("tgt_y", cif.target_position_y, my[l]);
      chk("ini_x", cif.initial_position_x, (l == 0) ? hx : mx[l-1]);
      chk("ini_y", cif.initial_position_y, (l == 0) ? hy : my[l-1]);
      cnt = 0;
      while (cif.ctrl_restart === 1'b1 && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      chk("rst_len", cnt, RC);
      if (rej && l == 0) chk("wr_rej_clear", wr_reject, 0);
      chk("run_en", cif.robot_controller_en, 1);
      chk("run_idx", wp_index, l);
      repeat (rdly) @(negedge clk);
      chk("run_hold", cif.robot_controller_en, 1);
      cif.target_reached = 1'b1;
      @(negedge clk);
      cif.target_reached = 1'b0;
      chk("next_en", cif.robot_controller_en, 0);
      chk("next_fault", fault, 0);
      @(negedge clk);
    end
    if (upto == n) begin
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_fault", fault, 0);
      chk("done_en", cif.robot_controller_en, 0);
      chk("done_tgt", cif.target_position_x, mx[n-1]);
    end
  endtask

  // Five ticks spaced three cycles apart; both=1 adds reached on the 5th.
  task automatic ticks5(input bit both);
    for (int k = 1; k <= 5; k++) begin
      tick_1ms = 1'b1;
      if (both && k == 5) cif.target_reached = 1'b1;
      #1;
      if (k < 5 || both) chk("to_fault_tick", fault, 0);
      else chk("to_fault_now", fault, 1);
      chk("to_en_tick", cif.robot_controller_en, 1);
      @(negedge clk);
      tick_1ms = 1'b0;
      cif.target_reached = 1'b0;
      if (k < 5) begin
        chk("to_en_gap", cif.robot_controller_en, 1);
        @(negedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdly;
    cif.target_reached = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_en", cif.robot_controller_en, 0);
    chk("rst_restart", cif.ctrl_restart, 0);
    chk("rst_tgt", cif.target_position_x, 0);
    chk("rst_idx", wp_index, 0);
    reset = 1'b1;
    @(negedge clk);

    wr(0, 32'd100, 32'd0);
    wr(1, 32'd100, 32'd200);
    wr(2, -32'sd50, 32'd200);
    set_home(32'd0, 32'd0);
    wp_count = 4'd3;
    go();
    legs(3, 3, 10, 1'b0);

    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(2, DEPTH);
      for (int a = 0; a < n; a++) wr(a, $urandom, $urandom);
      set_home($urandom, $urandom);
      rdly = $urandom_range(0, 12);
      wp_count = (AW+1)'(n);
      go();
      legs(n, n, rdly, 1'b0);
    end

    wp_count   = 4'd1;
    timeout_ms = 16'd5;
    go();
    repeat (RC + 1) @(negedge clk);
    chk("to_run", cif.robot_controller_en, 1);
    ticks5(1'b0);
    chk("to_en_off", cif.robot_controller_en, 0);
    chk("to_fault_hold", fault, 1);
    chk("to_busy", busy, 0);

    go();
    chk("sc_fault_clr", fault, 0);
    chk("sc_busy", busy, 1);
    repeat (RC + 1) @(negedge clk);
    ticks5(1'b1);
    chk("sc_next_en", cif.robot_controller_en, 0);
    chk("sc_next_fault", fault, 0);
    @(negedge clk);
    chk("sc_done", done, 1);
    chk("sc_fault_end", fault, 0);
    timeout_ms = 16'd0;

    wp_count = 4'd9;
    go();
    chk("bad_fault", fault, 2);
    chk("bad_busy", busy, 0);
    chk("bad_done", done, 0);
    for (int c = 0; c < 6; c++) begin
      chk("bad_en", cif.robot_controller_en, 0);
      @(negedge clk);
    end
    wp_count = 4'd0;
    go();
    chk("zero_done", done, 1);
    chk("zero_fault", fault, 0);
    chk("zero_busy", busy, 0);

    wp_count = 4'd3;
    go();
    legs(3, 1, 5, 1'b0);
    repeat (RC + 1) @(negedge clk);
    chk("ab_run_en", cif.robot_controller_en, 1);
    chk("ab_run_idx", wp_index, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_en", cif.robot_controller_en, 0);
    chk("ab_idx", wp_index, 0);
    chk("ab_done", done, 0);
    chk("ab_fault", fault, 0);
    chk("ab_busy", busy, 0);
    chk("ab_tgt", cif.target_position_x, mx[1]);
    go();
    legs(3, 3, 3, 1'b1);
    go();
    legs(3, 3, 2, 1'b0);

    go();
    repeat (RC + 1) @(negedge clk);
    chk("mr_run", cif.robot_controller_en, 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_en", cif.robot_controller_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_tgt", cif.target_position_x, 0);
    chk("mr_ini", cif.initial_position_y, 0);
    chk("mr_idx", wp_index, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/waypoint_sequencer.md
Name: waypoint_sequencer

Overview:
Sequences the autonomous drive controller through a programmable list of up to DEPTH (x,y) waypoints. For each leg it drives the target position inputs of the controller. It also drives the initial position and enable inputs. Between legs it pulses a controller restart, waits for the controller's target-reached flag, supervises a per-leg millisecond timeout, and reports progress and fault status to the host register block.

Parameters:
DEPTH, 8, number of waypoint table entries (power of 2, 2..16)
AW, 3, table address width, log2(DEPTH)
RESTART_CYCLES, 4, clock cycles ctrl_restart is held high per leg (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset (low = reset)
wp_wr_en  input  1  table write strobe
wp_wr_addr  input  AW  table write address
wp_wr_x  input  32  signed waypoint x (cm)
wp_wr_y  input  32  signed waypoint y (cm)
wp_count  input  AW+1  number of valid waypoints
home_x  input  32  signed start position x
home_y  input  32  signed start position y
start  input  1  level; sampled in IDLE/DONE
abort  input  1  level; forces IDLE
tick_1ms  input  1  one-cycle pulse per millisecond
timeout_ms  input  16  per-leg timeout, 0 = disabled
target_reached  input  1  from drive controller
target_position_x  output  32  signed, to controller
target_position_y  output  32  signed, to controller
initial_position_x  output  32  signed, to controller
initial_position_y  output  32  signed, to controller
robot_controller_en  output  1  controller enable
ctrl_restart  output  1  active-high controller reset
wp_index  output  AW  current leg index
busy  output  1  sequence in progress
done  output  1  all legs completed (sticky until start/abort)
fault  output  2  0 none, 1 timeout, 2 bad wp_count (sticky until start/abort)
wr_reject  output  1  one-cycle pulse: write ignored while busy

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0; table contents undefined (not reset).
- Table writes are accepted only when busy=0. A write with busy=1 is dropped and pulses wr_reject the next cycle.
- State IDLE/DONE/FAULT, start=1, abort=0:
  - wp_count==0: go to DONE, done=1.
  - wp_count>DEPTH: go to FAULT, fault=2.
  - Otherwise: idx=0, clear done and fault, go to LOAD. busy=1 from the next cycle.
- LOAD (1 cycle): target_position <= table[idx].
  - idx==0: initial_position <= home.
  - Otherwise: initial_position <= table[idx-1].
  - robot_controller_en <= 0. Next state RESTART.
- RESTART: ctrl_restart=1 for exactly RESTART_CYCLES cycles, then 0. Leg timer cleared. Next state RUN.
- RUN: robot_controller_en=1.
  - Each tick_1ms increments the 16-bit leg timer (saturating).
  - target_reached=1 → NEXT, checked before timeout.
  - Else timeout_ms!=0 and timer==timeout_ms → FAULT, fault=1.
  - target_reached and timer expiry in the same cycle: reached wins.
- NEXT (1 cycle): robot_controller_en=0.
  - idx==wp_count-1 → DONE.
  - Otherwise idx+1 → LOAD.
- DONE: done=1, busy=0, robot_controller_en=0. Targets held.
- FAULT: busy=0, robot_controller_en=0, ctrl_restart=0. Targets held.
- abort=1 in any state → IDLE next cycle. Effects: busy=0, robot_controller_en=0, ctrl_restart=0, done and fault cleared, targets held. abort has priority over start.
- target_reached is only examined in RUN. A stale high level from the previous leg is masked by the RESTART pulse.
- Latency: start to first ctrl_restart = 2 cycles; start to robot_controller_en = 2+RESTART_CYCLES cycles. Leg-to-leg gap = 2+RESTART_CYCLES cycles.
- wp_index equals idx at all times; it is 0 in IDLE.

Optional Feature:
WAYPOINT_LOOP_EN:
- Defined:
  - At the last leg, NEXT wraps idx to 0 and returns to LOAD instead of entering DONE.
  - The leg-0 initial position becomes table[wp_count-1] on wraps.
  - Extra output lap_count (8 bits) increments on each wrap, saturates at 255, and clears on start.
  - done never asserts except when wp_count==0.
- Undefined: no lap_count port; behaviour as above.

Test Plan:
- Write 3 waypoints (100,0),(100,200),(-50,200); home (0,0); wp_count=3; start; pulse target_reached 10 cycles into each RUN.
  - Required: targets and initials step as per table.
  - Required: ctrl_restart high 4 cycles per leg.
  - Required: wp_index steps 0→1→2, then done=1, busy=0.
- timeout_ms=5; no target_reached → fault=1 on the cycle of the 5th tick_1ms. robot_controller_en=0 the next cycle.
- wp_count=9 with DEPTH=8, start → fault=2, robot_controller_en never asserted. wp_count=0, start → done=1 immediately.
- Assert abort during leg 1 RUN → IDLE next cycle, robot_controller_en=0, wp_index=0, done=0, fault=0. Then start → sequence restarts at leg 0.
- Write while busy → wr_reject pulse, table entry unchanged (verified by re-running). Drive reset low mid-RUN → all outputs 0 asynchronously.
- target_reached and the 5th tick in the same cycle → NEXT, fault stays 0. With WAYPOINT_LOOP_EN, two full passes → lap_count=2.
